// File: rtl/apb_slave_regs.sv
// APB3 slave with an 8-entry register map: ID, six RW registers and a completed-transfer counter.
// Every transfer is latched in its setup phase and completes after WAIT_CYCLES extra access cycles.
`timescale 1ns/1ps
module apb_slave_regs #(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter logic [31:0] ID_VALUE    = 32'hA5B0_0001
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  r_state;
  logic [31:2] r_addr;
  logic        r_write;
  logic [31:0] r_wdata;
  logic [3:0]  r_cnt;
  logic [31:0] r_regs [1:6];
  logic [31:0] r_xfer_cnt;

  logic [2:0]  w_idx;
  logic        w_err;
  logic [31:0] w_rdata;
  logic        w_unused;

  // Byte-lane bits of the address carry no meaning for word registers.
  assign w_unused = ^PADDR[1:0];

  assign w_idx = r_addr[4:2];
  assign w_err = (r_addr[31:5] != '0) || (r_write && ((w_idx == 3'd0) || (w_idx == 3'd7)));

  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    w_rdata = '0;
    case (w_idx)
      3'd0:    w_rdata = ID_VALUE;
      3'd1:    w_rdata = r_regs[1];
      3'd2:    w_rdata = r_regs[2];
      3'd3:    w_rdata = r_regs[3];
      3'd4:    w_rdata = r_regs[4];
      3'd5:    w_rdata = r_regs[5];
      3'd6:    w_rdata = r_regs[6];
      3'd7:    w_rdata = r_xfer_cnt;
      default: w_rdata = '0;
    endcase
  end

  // NOTE: state is assigned with <= so every flop samples pre-edge values of its peers.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_write    <= 1'b0;
      r_wdata    <= '0;
      r_cnt      <= '0;
      r_xfer_cnt <= '0;
      PRDATA     <= '0;
      PREADY     <= 1'b0;
      PSLVERR    <= 1'b0;
      // NOTE: the register file is reset (so it maps to flops, not RAM) because it must read 0 after reset.
      for (int i = 1; i <= 6; i++) r_regs[i] <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (PSEL && !PENABLE) begin
            r_addr  <= PADDR[31:2];
            r_write <= PWRITE;
            r_wdata <= PWDATA;
            r_cnt   <= 4'(WAIT_CYCLES);
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (!PSEL) begin
            r_state <= S_IDLE;
          end else if (PENABLE) begin
            if (r_cnt != '0) begin
              r_cnt <= r_cnt - 4'd1;
            end else begin
              PREADY  <= 1'b1;
              PSLVERR <= w_err;
              r_state <= S_DONE;
              if (w_err) begin
                if (!r_write) PRDATA <= '0;
              end else begin
                // The counter read path sees the pre-increment value of this same transfer.
                r_xfer_cnt <= r_xfer_cnt + 32'd1;
                if (r_write) begin
                  for (int i = 1; i <= 6; i++)
                    if (w_idx == 3'(i)) r_regs[i] <= r_wdata;
                end else begin
                  PRDATA <= w_rdata;
                end
              end
            end
          end
        end
        S_DONE: begin
          PREADY  <= 1'b0;
          PSLVERR <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_slave_regs.sv
// Directed bench for apb_slave_regs: the master pushes hand-computed responses into a queue
// and an independent monitor pops and compares them whenever PREADY is seen.
`timescale 1ns/1ps
module tb_apb_slave_regs;

  localparam int WC = 1;
  localparam logic [31:0] ID = 32'hA5B0_0001;

  logic        PCLK;
  logic        PRESETn;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  logic [31:0] p0_rdata_unused;
  logic        p0_err_unused;
  logic        ready0;
  logic [31:0] p4_rdata_unused;
  logic        p4_err_unused;
  logic        ready4;

  apb_slave_regs #(.WAIT_CYCLES(WC), .ID_VALUE(ID)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  // Latency-only instances sharing the same bus.
  apb_slave_regs #(.WAIT_CYCLES(0), .ID_VALUE(ID)) dut_w0 (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(p0_rdata_unused), .PREADY(ready0), .PSLVERR(p0_err_unused)
  );

  apb_slave_regs #(.WAIT_CYCLES(4), .ID_VALUE(ID)) dut_w4 (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(p4_rdata_unused), .PREADY(ready4), .PSLVERR(p4_err_unused)
  );

  typedef struct {
    string       name;
    logic        err;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;
  always @(posedge PCLK) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compare the oldest expectation whenever PREADY is presented.
  exp_t        mon_e;
  bit          prev_ready = 1'b0;
  logic [31:0] hold_exp   = '0;

  always @(negedge PCLK) begin
    if (PREADY === 1'b1) begin
      if (prev_ready) begin
        check("pready_one_cycle", {31'd0, prev_ready}, 32'd0);
      end else if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pready: got PREADY=1 expected no transfer (cycle %0d)", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check({mon_e.name, "_pslverr"}, {31'd0, PSLVERR}, {31'd0, mon_e.err});
        check({mon_e.name, "_prdata"}, PRDATA, mon_e.rdata);
        check({mon_e.name, "_latency"}, 32'(cyc), 32'(mon_e.cyc));
        hold_exp = mon_e.rdata;
      end
    end else if (prev_ready) begin
      check("prdata_hold_after_done", PRDATA, hold_exp);
      check("pslverr_clear_after_done", {31'd0, PSLVERR}, 32'd0);
    end
    prev_ready = (PREADY === 1'b1);
  end

  // Full transfer; called at #1 after a rising edge, returns at #1 after the completion edge.
  task automatic xfer(input string name, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic exp_err, input logic [31:0] exp_rdata,
                      input bit scramble = 1'b0);
    exp_t e;
    int   n;
    e.name  = name;
    e.err   = exp_err;
    e.rdata = exp_rdata;
    e.cyc   = cyc + WC + 2;
    exp_q.push_back(e);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    if (scramble) begin
      PWRITE = ~wr; PADDR = 32'h0000_0008; PWDATA = 32'h0;
    end
    n = 0;
    forever begin
      @(negedge PCLK);
      if (PREADY === 1'b1) break;
      n++;
      if (n > 50) begin
        checks++;
        failures++;
        $display("FAIL %s_timeout: got no PREADY expected PREADY within 50 cycles", name);
        break;
      end
    end
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  // Setup plus one access cycle, then abandon via PSEL drop or reset; no response is expected.
  task automatic xfer_abort(input logic [31:0] addr, input logic [31:0] wdata, input bit by_reset);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = addr; PWDATA = wdata;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    if (by_reset) begin
      PRESETn = 1'b0;
      #1;
      check("reset_mid_wait_pready", {31'd0, PREADY}, 32'd0);
      check("reset_mid_wait_prdata", PRDATA, 32'd0);
      check("reset_mid_wait_pslverr", {31'd0, PSLVERR}, 32'd0);
    end
    PSEL = 1'b0; PENABLE = 1'b0;
    repeat (3) @(posedge PCLK);
    #1;
    if (by_reset) PRESETn = 1'b1;
  endtask

  int c0;
  int rise0;
  int rise4;
  int hi0;
  int hi4;

  initial begin
    PRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
    #2;
    check("reset_pready", {31'd0, PREADY}, 32'd0);
    check("reset_pslverr", {31'd0, PSLVERR}, 32'd0);
    check("reset_prdata", PRDATA, 32'd0);
    repeat (2) @(posedge PCLK);
    #1;
    PRESETn = 1'b1;

    // Latency for WAIT_CYCLES 0/1/4 with access held long; late IDLE access phases must be ignored.
    exp_q.push_back('{name: "lat_read_id", err: 1'b0, rdata: ID, cyc: cyc + WC + 2});
    c0 = cyc; rise0 = -1; rise4 = -1; hi0 = 0; hi4 = 0;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 32'h0;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge PCLK);
      if (ready0 === 1'b1) begin hi0++; if (rise0 < 0) rise0 = cyc; end
      if (ready4 === 1'b1) begin hi4++; if (rise4 < 0) rise4 = cyc; end
    end
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
    check("lat_w0_rise_cycle", 32'(rise0), 32'(c0 + 2));
    check("lat_w4_rise_cycle", 32'(rise4), 32'(c0 + 6));
    check("lat_w0_high_cycles", 32'(hi0), 32'd1);
    check("lat_w4_high_cycles", 32'(hi4), 32'd1);

    // Write then read back reg1; counter is 1 after the ID read.
    xfer("wr_04_deadbeef", 1'b1, 32'h04, 32'hDEAD_BEEF, 1'b0, ID);
    xfer("rd_04", 1'b0, 32'h04, 32'h0, 1'b0, 32'hDEAD_BEEF);

    // ID register is read-only.
    xfer("rd_00", 1'b0, 32'h00, 32'h0, 1'b0, ID);
    xfer("wr_00_err", 1'b1, 32'h00, 32'h1234_5678, 1'b1, ID);
    xfer("rd_00_again", 1'b0, 32'h00, 32'h0, 1'b0, ID);

    // Out-of-range read errors with PRDATA 0; counter has 5 good completions so far.
    xfer("rd_40_err", 1'b0, 32'h40, 32'h0, 1'b1, 32'h0);
    xfer("rd_1c_cnt5", 1'b0, 32'h1C, 32'h0, 1'b0, 32'd5);

    // PSEL dropped during WAIT: no write, no count.
    xfer_abort(32'h04, 32'h1111_1111, 1'b0);
    xfer("rd_04_after_abort", 1'b0, 32'h04, 32'h0, 1'b0, 32'hDEAD_BEEF);
    xfer("rd_1c_cnt7", 1'b0, 32'h1C, 32'h0, 1'b0, 32'd7);

    // Master changes address/data/direction during access; latched setup values must win.
    xfer("wr_18_scrambled", 1'b1, 32'h18, 32'hCAFE_F00D, 1'b0, 32'd7, 1'b1);
    xfer("rd_18", 1'b0, 32'h18, 32'h0, 1'b0, 32'hCAFE_F00D);
    xfer("rd_08_untouched", 1'b0, 32'h08, 32'h0, 1'b0, 32'h0);
    xfer("rd_1b_lowbits", 1'b0, 32'h1B, 32'h0, 1'b0, 32'hCAFE_F00D);
    xfer("wr_hi_addr_err", 1'b1, 32'h8000_0004, 32'h2222_2222, 1'b1, 32'hCAFE_F00D);
    xfer("rd_04_unchanged", 1'b0, 32'h04, 32'h0, 1'b0, 32'hDEAD_BEEF);

    // Reset during WAIT, then back-to-back writes starting on the first edge after release.
    xfer_abort(32'h14, 32'h0000_0055, 1'b1);
    xfer("b2b_wr_08", 1'b1, 32'h08, 32'h0808_0808, 1'b0, 32'h0);
    xfer("b2b_wr_0c", 1'b1, 32'h0C, 32'h0C0C_0C0C, 1'b0, 32'h0);
    xfer("b2b_wr_10", 1'b1, 32'h10, 32'h1010_1010, 1'b0, 32'h0);
    xfer("rd_1c_cnt3", 1'b0, 32'h1C, 32'h0, 1'b0, 32'd3);
    xfer("rd_1c_cnt4", 1'b0, 32'h1C, 32'h0, 1'b0, 32'd4);
    xfer("rd_14_not_written", 1'b0, 32'h14, 32'h0, 1'b0, 32'h0);
    xfer("rd_04_cleared", 1'b0, 32'h04, 32'h0, 1'b0, 32'h0);
    xfer("rd_08_b2b", 1'b0, 32'h08, 32'h0, 1'b0, 32'h0808_0808);
    xfer("rd_10_b2b", 1'b0, 32'h10, 32'h0, 1'b0, 32'h1010_1010);

    repeat (5) @(posedge PCLK);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
